// File: rtl/cnn_pkg.sv
// +------------------------------------------------------------------+
// | cnn_pkg : shared CNN datapath types and constants                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int NUM_CH     = 4;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } pool_state_t;

endpackage

`default_nettype wire

// File: rtl/ram.sv
// +------------------------------------------------------------------+
// | ram : generic single-write, asynchronous-read storage array      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read; the caller registers it, so a same-edge write
  // is seen as old data.
  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/l2_pool.sv
// +------------------------------------------------------------------+
// | l2_pool : 2x2 pooling of layer_2 window stream into feature RAM  |
// | Max pooling by default; L2_POOL_AVG_EN selects average pooling.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module l2_pool
  import cnn_pkg::pool_state_t, cnn_pkg::COLLECT, cnn_pkg::DONE;
#(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 4,
  parameter int WIN        = 4,
  parameter int NUM_POS    = 25,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tx_done,
  input  logic                         in_vld,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         pool_vld,
  output logic        [DATA_WIDTH-1:0] pool_data,
  output logic        [1:0]            pool_ch,
  output logic        [4:0]            pool_pos,
  output logic                         frame_done,
  input  logic                         rd_en,
  input  logic        [ADDR_WIDTH-1:0] rd_addr,
  output logic                         rd_vld,
  output logic        [DATA_WIDTH-1:0] dout
);

  localparam int SMP_W = $clog2(WIN);
`ifdef L2_POOL_AVG_EN
  localparam int ACC_W = DATA_WIDTH + 2;
`else
  localparam int ACC_W = DATA_WIDTH;
`endif

  pool_state_t             state;
  logic [SMP_W-1:0]        smp_cnt;
  logic [1:0]              ch_cnt;
  logic [4:0]              pos_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [DATA_WIDTH-1:0]   result;
  logic                    take;
  logic                    last;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   ram_q;

  assign take    = in_vld && !tx_done && (state == COLLECT);
  assign last    = take && (smp_cnt == SMP_W'(WIN - 1));
  assign wr_addr = ADDR_WIDTH'({pos_cnt, ch_cnt});

`ifdef L2_POOL_AVG_EN
  always_comb begin
    acc_nxt = ACC_W'(din);
    if (smp_cnt != '0) acc_nxt = acc + ACC_W'(din);
    result = DATA_WIDTH'(acc_nxt >>> 2);
  end
`else
  always_comb begin
    acc_nxt = din;
    if ((smp_cnt != '0) && !(din > acc)) acc_nxt = acc;
    result = acc_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      smp_cnt    <= '0;
      ch_cnt     <= '0;
      pos_cnt    <= '0;
      acc        <= '0;
      pool_vld   <= 1'b0;
      pool_data  <= '0;
      pool_ch    <= '0;
      pool_pos   <= '0;
      frame_done <= 1'b0;
    end else if (tx_done) begin
      state      <= COLLECT;
      smp_cnt    <= '0;
      ch_cnt     <= '0;
      pos_cnt    <= '0;
      acc        <= '0;
      pool_vld   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pool_vld <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_vld) begin
            acc <= acc_nxt;
            if (last) begin
              smp_cnt   <= '0;
              pool_vld  <= 1'b1;
              pool_data <= result;
              pool_ch   <= ch_cnt;
              pool_pos  <= pos_cnt;
              ch_cnt    <= ch_cnt + 2'd1;
              if (ch_cnt == 2'(NUM_CH - 1)) begin
                ch_cnt <= '0;
                // Final write of the frame: stop here so pos_cnt never wraps.
                if (pos_cnt == 5'(NUM_POS - 1)) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                end else begin
                  pos_cnt <= pos_cnt + 5'd1;
                end
              end
            end else begin
              smp_cnt <= smp_cnt + SMP_W'(1);
            end
          end
        end
        DONE:    frame_done <= 1'b1;
        default: state <= COLLECT;
      endcase
    end
  end

  ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (last),
    .waddr(wr_addr),
    .wdata(result),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      dout   <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) dout <= ram_q;
    end
  end

endmodule

`default_nettype wire

// File: doc/l2_pool.md
Name: l2_pool

Overview:
- 2x2 pooling stage directly downstream of layer_2.
- Consumes layer_2's serial window stream: per output position, 4 samples for ch0, then 4 for ch1, ch2 and ch3.
- Reduces each 4-sample group to one value and stores it in a pooled feature RAM addressed {pos, ch}.
- The dense layer downstream reads that RAM through a 1-cycle-latency read port.

Parameters:
- DATA_WIDTH, 18, sample width (signed).
- NUM_CH, 4, channels per position (power of 2).
- WIN, 4, samples per pooling group.
- NUM_POS, 25, pooled positions per frame (5x5).
- ADDR_WIDTH, 7, pooled RAM address width; must be ≥ clog2(NUM_POS) + clog2(NUM_CH).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_done  input  1  frame clear, synchronous; same signal layer_2 uses.
- in_vld  input  1  din valid this cycle.
- din  input  DATA_WIDTH  signed sample from layer_2.
- pool_vld  output  1  one-cycle pulse, pooled result produced.
- pool_data  output  DATA_WIDTH  pooled result.
- pool_ch  output  2  channel of pool_data.
- pool_pos  output  5  position of pool_data.
- frame_done  output  1  sticky; all NUM_POS*NUM_CH results written.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address, {pos, ch}.
- rd_vld  output  1  dout valid.
- dout  output  DATA_WIDTH  read data.

Behaviour:
Reset values:
- All outputs 0.
- smp_cnt = 0, ch_cnt = 0, pos_cnt = 0, acc = 0, state COLLECT.

State machine (2 states):
- COLLECT
  - While in_vld, count samples.
  - On smp_cnt 0: acc <= din.
  - Otherwise: acc <= (din > acc, signed) ? din : acc.
  - On smp_cnt == WIN-1:
    - Register the result (final compare included), smp_cnt <= 0.
    - Assert RAM write with addr {pos_cnt, ch_cnt}.
    - Pulse pool_vld next cycle with pool_data, pool_ch and pool_pos.
    - ch_cnt increments; on wrap from NUM_CH-1, pos_cnt increments.
    - On pos_cnt == NUM_POS-1 and ch_cnt == NUM_CH-1: go to DONE.
- DONE
  - frame_done = 1; in_vld is ignored (no writes, no pool_vld).
  - Left only via tx_done or reset.

Latency:
- Last sample of a group to pool_vld: 1 cycle.
- RAM write occurs in the same edge that raises pool_vld.
- in_vld may be gapped arbitrarily; a group does not need consecutive cycles.

tx_done (highest priority, any state or mid-group):
- Clears smp_cnt, ch_cnt, pos_cnt, acc, frame_done and pool_vld; returns to COLLECT.
- Any same-cycle in_vld sample is dropped.
- RAM contents are not cleared.

Read port:
- rd_en at edge N gives dout and rd_vld at edge N+1; dout holds its value otherwise.
- A same-cycle read and write to the same address returns the old data.
- Reads are legal at any time; they are meaningful after frame_done.

Arithmetic:
- Signed comparison over the full DATA_WIDTH; no truncation in max mode.
- pos_cnt never exceeds NUM_POS-1 (no wrap), because the FSM enters DONE first.

Optional Feature:
- Macro L2_POOL_AVG_EN selects average pooling.
- Defined:
  - acc is DATA_WIDTH+2 bits signed.
  - Sample 0 loads the sign-extended din; later samples add.
  - Result = acc >>> 2 (arithmetic shift, truncating toward -inf), taken as the low DATA_WIDTH bits.
- Undefined: max pooling as above; the avg adder is absent.

Decomposition:
- Package cnn_pkg:
  - DATA_WIDTH (18), NUM_CH (4).
  - typedef logic signed [DATA_WIDTH-1:0] data_t.
  - typedef enum {COLLECT, DONE} pool_state_t.
- Sub-module: the existing generic ram instantiated with #(.ADDR_WIDTH(7), .DATA_WIDTH(18)) for the pooled store.
  - The read-register/rd_vld wrapper lives in l2_pool.

Test Plan:
1. Max, position 0: ch0 samples 5, 9, 3, 7 → pool_vld one cycle after 4th sample, pool_data 9, pool_ch 0, pool_pos 0; RAM[0] = 9.
2. Signed compare: group −4, −1, −8, −2 → pool_data −1 (0x3FFFF).
3. Full frame: 400 samples at in_vld = 1 with gaps of 0–3 idle cycles between samples → 100 pool_vld pulses and frame_done after the last write; 401st valid sample → no pool_vld and no write. Then rd_addr = {24, 3} → dout on the next cycle equals the expected max, with rd_vld = 1.
4. tx_done after 2 samples of a group, coincident with a valid 3rd sample → counters return to 0 and that sample is dropped. Group 1, 2, 3, 4 → pool_data 4, pool_ch 0, pool_pos 0.
5. Reset mid-frame (pos 7) → all outputs 0 immediately; the next group writes addr 0.
6. With L2_POOL_AVG_EN defined: group 4, 8, 12, 16 → pool_data 10; group −1, −1, −1, −2 → −2.
